// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: RAM read port plus the valid/ready output stream
interface ram_stream_reader_if #(
  parameter int ADDR = 12,
  parameter int DATA = 10
);
  logic [ADDR-1:0] rd_addr;
  logic            rd_en;
  logic [DATA-1:0] rd_data;
  logic [DATA-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  modport master (
    output rd_addr, rd_en, out_data, out_valid,
    input  rd_data, out_ready
  );
  modport slave (
    input  rd_addr, rd_en, out_data, out_valid,
    output rd_data, out_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: bursts words out of a 1-cycle-latency RAM into a valid/ready stream
module ram_stream_reader #(
  parameter int ADDR = 12,
  parameter int DATA = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR-1:0]     base_addr,
  input  logic [ADDR:0]       length,
  output logic                busy,
  output logic                done,
  ram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t          state, state_nxt;
  logic [ADDR-1:0] base_q;
  logic [ADDR:0]   len_q, issued, issued_nxt;
  logic [DATA-1:0] mem [2];
  logic [1:0]      cnt;
  logic [2:0]      occ;
  logic            rptr, wptr, inflight, push, pop, accept, drain_end;
  assign issued_nxt    = issued + (ADDR+1)'(1);
  assign push          = inflight;
  assign pop           = bus.out_valid & bus.out_ready;
  // Words already held or on their way, after this cycle's pop; keeps the FIFO at <= 2.
  assign occ           = 3'(cnt) + 3'(inflight) - 3'(pop);
  assign accept        = state == IDLE && start && !abort && length != '0;
  assign drain_end     = !inflight && (cnt == 2'd0 || (cnt == 2'd1 && pop));
  assign bus.out_valid = cnt != 2'd0;
  assign bus.out_data  = mem[rptr];
  assign bus.rd_addr   = base_q + issued[ADDR-1:0];
  // State register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  // Next-state logic; abort wins over every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN:     state_nxt = abort ? IDLE : (bus.rd_en && issued_nxt == len_q) ? DRAIN : RUN;
      DRAIN:   state_nxt = (abort || drain_end) ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // Outputs: reads are issued only in RUN while the credit allows
  always_comb begin
    bus.rd_en = state == RUN && occ < 3'd2 && issued < len_q;
    busy      = state != IDLE;
  end
  // Burst bookkeeping, returned-data capture and the 2-entry FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      cnt      <= 2'd0;
      rptr     <= 1'b0;
      wptr     <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      done     <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        len_q  <= length;
        issued <= '0;
      end else if (bus.rd_en) begin
        issued <= issued_nxt;
      end
      inflight <= bus.rd_en && !abort;
      done     <= !abort && ((state == IDLE && start && length == '0) || (state == DRAIN && drain_end));
      if (abort) begin
        cnt  <= 2'd0;
        rptr <= 1'b0;
        wptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wptr] <= bus.rd_data;
          wptr      <= ~wptr;
        end
        if (pop) rptr <= ~rptr;
        cnt <= cnt + 2'(push) - 2'(pop);
      end
    end
  end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bench with a behavioural 1-cycle RAM
module tb_ram_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0;
  logic        busy, done;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, t0 = 0, first_v = -1, done_t = -1, dones = 0, d0 = 0, maxc = 0;
  logic [9:0]  got[$];
  logic [11:0] addrs[$];
  logic        pv, pr;
  logic [9:0]  pd;
  ram_stream_reader_if #(.ADDR(12), .DATA(10)) bus ();
  ram_stream_reader #(.ADDR(12), .DATA(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] mw(input logic [11:0] a);
    return a[9:0] ^ {a[11:10], 8'hC3};
  endfunction
  always @(posedge clk)
    if (bus.rd_en) bus.rd_data <= mw(bus.rd_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.out_valid && first_v < 0) first_v = cyc;
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    if (bus.rd_en) addrs.push_back(bus.rd_addr);
    if (done) begin dones++; done_t = cyc; end
    if (int'(dut.cnt) > maxc) maxc = int'(dut.cnt);
  endtask
  task automatic begin_burst(input logic [11:0] b, input logic [12:0] l);
    got.delete(); addrs.delete();
    first_v = -1; done_t = -1; maxc = 0; d0 = dones;
    base_addr = b; length = l; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && dones == d0; i++) tick();
    chk(tag, 32'(dones - d0), 1);
  endtask
  task automatic check_words(input string tag, input logic [11:0] b, input int n);
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_word"}, 32'(got[i]), 32'(mw(b + 12'(i))));
  endtask
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    rst_n = 1'b1;
    tick();
    // basic burst at 0x010, length 4, sink always ready
    begin_burst(12'h010, 13'd4);
    chk("b1_rd_en", 32'(bus.rd_en), 1);
    chk("b1_addr0", 32'(bus.rd_addr), 32'h010);
    chk("b1_busy", 32'(busy), 1);
    wait_done("b1_done", 30);
    chk("b1_naddr", 32'(addrs.size()), 4);
    for (int i = 0; i < addrs.size(); i++) chk("b1_addr", 32'(addrs[i]), 32'h010 + 32'(i));
    check_words("b1", 12'h010, 4);
    chk("b1_first_valid", 32'(first_v - t0), 3);
    chk("b1_done_time", 32'(done_t - t0), 7);
    chk("b1_busy_end", 32'(busy), 0);
    tick();
    chk("b1_single_done", 32'(dones - d0), 1);
    // address wrap at the top of the RAM
    begin_burst(12'hFFE, 13'd4);
    wait_done("b2_done", 30);
    chk("b2_naddr", 32'(addrs.size()), 4);
    chk("b2_a0", 32'(addrs[0]), 32'hFFE);
    chk("b2_a1", 32'(addrs[1]), 32'hFFF);
    chk("b2_a2", 32'(addrs[2]), 32'h000);
    chk("b2_a3", 32'(addrs[3]), 32'h001);
    check_words("b2", 12'hFFE, 4);
    // sink toggling ready every cycle
    begin_burst(12'h200, 13'd8);
    for (int i = 0; i < 80 && dones == d0; i++) begin
      bus.out_ready = ~bus.out_ready;
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
      tick();
      if (pv && !pr) begin
        chk("b3_stall_valid", 32'(bus.out_valid), 1);
        chk("b3_stall_data", 32'(bus.out_data), 32'(pd));
      end
    end
    chk("b3_done", 32'(dones - d0), 1);
    check_words("b3", 12'h200, 8);
    chk("b3_max_fifo_le2", 32'(maxc <= 2), 1);
    bus.out_ready = 1'b1;
    tick();
    // zero-length start
    begin_burst(12'h123, 13'd0);
    chk("b4_done", 32'(done), 1);
    chk("b4_busy", 32'(busy), 0);
    tick(); tick();
    chk("b4_no_rd", 32'(addrs.size()), 0);
    chk("b4_busy_later", 32'(busy), 0);
    chk("b4_one_done", 32'(dones - d0), 1);
    // abort a stalled burst, then restart elsewhere
    bus.out_ready = 1'b0;
    begin_burst(12'h300, 13'd16);
    for (int i = 0; i < 4; i++) tick();
    chk("b5_fifo_full", 32'(dut.cnt), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("b5_out_valid", 32'(bus.out_valid), 0);
    chk("b5_busy", 32'(busy), 0);
    chk("b5_rd_en", 32'(bus.rd_en), 0);
    tick(); tick();
    chk("b5_no_done", 32'(dones - d0), 0);
    bus.out_ready = 1'b1;
    begin_burst(12'h050, 13'd2);
    wait_done("b5_restart_done", 30);
    check_words("b5r", 12'h050, 2);
    // abort and start together in IDLE
    abort = 1'b1;
    begin_burst(12'h060, 13'd3);
    abort = 1'b0;
    chk("b6_busy", 32'(busy), 0);
    chk("b6_done", 32'(done), 0);
    // reset in the middle of a burst
    begin_burst(12'h400, 13'd8);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("b7_rd_en", 32'(bus.rd_en), 0);
    chk("b7_rd_addr", 32'(bus.rd_addr), 0);
    chk("b7_out_valid", 32'(bus.out_valid), 0);
    chk("b7_out_data", 32'(bus.out_data), 0);
    chk("b7_busy", 32'(busy), 0);
    chk("b7_done", 32'(done), 0);
    tick();
    chk("b7_stale_ignored", 32'(bus.out_valid), 0);
    begin_burst(12'h100, 13'd2);
    wait_done("b7_done2", 30);
    check_words("b7", 12'h100, 2);
    tick(); tick();
    chk("b7_no_extra", 32'(got.size()), 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter: ADDR, default 12, RAM address width in bits.
REQ-002 Parameter: DATA, default 10, RAM word width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 abort  input  1  terminates any burst in progress.
REQ-007 base_addr  input  ADDR  first RAM word address, latched on accepted start.
REQ-008 length  input  ADDR+1  words to read, 0..2**ADDR, latched on accepted start.
REQ-009 rd_addr  output  ADDR  RAM read address.
REQ-010 rd_en  output  1  RAM read enable; the RAM returns the word one cycle after rd_en.
REQ-011 rd_data  input  DATA  RAM read data, valid in the cycle after rd_en.
REQ-012 out_data  output  DATA  stream word.
REQ-013 out_valid  output  1  out_data holds a valid word.
REQ-014 out_ready  input  1  sink accepts the word when out_valid and out_ready are both high.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when a burst completes normally.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-018 IDLE->RUN SHALL occur on start=1 with length>0; base_addr and length SHALL be latched in that cycle.
REQ-019 start=1 with length=0 in IDLE SHALL pulse done in the next cycle, issue no read, and stay in IDLE.
REQ-020 In RUN, rd_en SHALL be asserted when (fifo_count + inflight - pop) < 2 and issued < length, where pop = out_valid & out_ready.
REQ-021 Each issued read SHALL use rd_addr = base_addr + issued, modulo 2**ADDR; the address wraps from 2**ADDR-1 to 0.
REQ-022 inflight SHALL be a 1-bit flag set by rd_en; the returned rd_data SHALL be written into a 2-entry FIFO in the following cycle.
REQ-023 out_valid SHALL equal FIFO non-empty, and out_data SHALL equal the FIFO head; a simultaneous push and pop SHALL keep the count unchanged.
REQ-024 The FIFO SHALL never overflow; this is guaranteed by the credit rule in REQ-020 under any out_ready pattern.
REQ-025 Words SHALL be delivered in address order with none dropped or duplicated, and out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 RUN->DRAIN SHALL occur in the cycle the last read is issued (issued reaches length).
REQ-027 DRAIN->IDLE SHALL occur when inflight=0 and the FIFO empties; done SHALL pulse in the cycle after the last word is accepted.
REQ-028 With out_ready held high, throughput SHALL be 1 word/cycle, and the first out_valid SHALL appear 3 cycles after the cycle in which start was sampled.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 abort=1 in RUN or DRAIN SHALL in the next cycle force IDLE, empty the FIFO, clear inflight, and drive out_valid=0, rd_en=0 and busy=0, with no done pulse.
REQ-031 If abort and start are both high in IDLE, abort SHALL take priority and no burst SHALL begin.
REQ-032 rd_en SHALL be 0 outside RUN.

Reset
REQ-033 rst_n=0 sampled at a clock edge SHALL force: state=IDLE; FIFO empty; inflight=0; issued=0; rd_en=0; rd_addr=0; out_valid=0; out_data=0; busy=0; done=0.
REQ-034 Reset asserted mid-burst SHALL discard all pending data, and an rd_data return arriving after reset SHALL be ignored.

Verification
REQ-035 base_addr=0x010, length=4, out_ready=1 -> rd_en high for 4 cycles at 0x010..0x013; out_data = mem[0x010..0x013] on consecutive cycles starting 3 cycles after start; done pulses once; busy falls.
REQ-036 base_addr=0xFFE, length=4 -> rd_addr sequence 0xFFE, 0xFFF, 0x000, 0x001; four words delivered in that order.
REQ-037 length=8, out_ready toggling 1/0 every cycle -> all 8 words are delivered exactly once, in order; out_data is stable while stalled; the FIFO count never exceeds 2.
REQ-038 start with length=0 -> done pulses the next cycle; no rd_en; busy stays 0.
REQ-039 length=16, out_ready=0, abort after 5 cycles -> next cycle out_valid=0, busy=0, no done pulse; a new start then reads correctly from its own base_addr.
REQ-040 rst_n=0 for 1 cycle mid-burst, then length=2 at 0x100 -> all outputs at their reset values; the second burst delivers mem[0x100], mem[0x101] with no stale word.
